// File: rtl/fx_requant_stream_pkg.sv
// Shared fixed-point definitions: mode encodings plus width and range-limit helpers
// used by the requantization pipeline.
package fx_requant_stream_pkg;

    typedef enum logic [1:0] {
        RND_FLOOR      = 2'd0,
        RND_HALF_UP    = 2'd1,
        RND_CONVERGENT = 2'd2,
        RND_TO_ZERO    = 2'd3
    } rndMode_e;

    typedef enum logic {
        OVF_WRAP = 1'b0,
        OVF_SAT  = 1'b1
    } ovfMode_e;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Quantized width before range limiting; the extra bit absorbs the rounding carry.
    function automatic int midWidth(input int inW, input int inFrac, input int outFrac);
        return inW - maxOf(inFrac - outFrac, 0) + maxOf(outFrac - inFrac, 0) + 1;
    endfunction

    function automatic longint outMax(input int outW);
        return (longint'(1) << (outW - 1)) - 1;
    endfunction

    function automatic longint outMin(input int outW);
        return -(longint'(1) << (outW - 1));
    endfunction

endpackage

// File: rtl/fx_round_stage.sv
// First pipeline stage: rescales the input to the output fraction using the
// per-sample rounding mode and registers the result with its overflow mode.
module fx_round_stage
    import fx_requant_stream_pkg::*;
#(
    parameter int IN_W     = 13,
    parameter int IN_FRAC  = 8,
    parameter int OUT_FRAC = 4,
    parameter int MID_W    = midWidth(IN_W, IN_FRAC, OUT_FRAC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [IN_W-1:0]  data_i,
    input  logic [1:0]       rnd_i,
    input  logic             sat_i,
    input  logic             advance_i,
    output logic             valid_o,
    output logic [MID_W-1:0] data_o,
    output logic             sat_o
);

    localparam int D = IN_FRAC - OUT_FRAC;

    logic [MID_W-1:0] quant;
    logic             valid_q, valid_d;
    logic [MID_W-1:0] data_q, data_d;
    logic             sat_q, sat_d;
    logic             load;

    generate
        if (D > 0) begin : gDrop
            localparam logic [IN_W:0] ONE      = (IN_W + 1)'(1);
            localparam logic [IN_W:0] HALF     = ONE << (D - 1);
            localparam logic [IN_W:0] LSB_MASK = (ONE << D) - ONE;

            logic [IN_W:0] extData;
            logic [IN_W:0] bias;
            logic [IN_W:0] sum;
            logic          unusedLowBits;

            // Every mode is a bias added before a floor shift; convergent biases by
            // half-minus-one plus the kept LSB so exact halves land on an even result.
            always_comb begin
                extData = {data_i[IN_W-1], data_i};
                bias    = '0;
                case (rndMode_e'(rnd_i))
                    RND_FLOOR:      bias = '0;
                    RND_HALF_UP:    bias = HALF;
                    RND_CONVERGENT: bias = HALF - ONE + (IN_W + 1)'(data_i[D]);
                    RND_TO_ZERO:    bias = data_i[IN_W-1] ? LSB_MASK : '0;
                    default:        bias = '0;
                endcase
                sum = extData + bias;
            end

            assign quant         = sum[IN_W:D];
            assign unusedLowBits = ^sum[D-1:0];
        end else begin : gShift
            localparam int SH = -D;
            assign quant = MID_W'(signed'(data_i)) << SH;
        end
    endgenerate

    assign ready_o = !valid_q || advance_i;
    assign load    = valid_i && ready_o;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sat_d   = sat_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = quant;
            sat_d   = sat_i;
        end else if (advance_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/fx_requant_stream.sv
// Two-stage streaming requantizer: rounding stage, then range limiting into the
// output register, with saturating positive/negative overflow event counters.
module fx_requant_stream
    import fx_requant_stream_pkg::*;
#(
    parameter int IN_W     = 13,
    parameter int IN_FRAC  = 8,
    parameter int OUT_W    = 8,
    parameter int OUT_FRAC = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [IN_W-1:0]  i_data,
    input  logic [1:0]       i_rnd,
    input  logic             i_sat,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [OUT_W-1:0] o_data,
    output logic             o_ovf,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ovf_pos_cnt,
    output logic [CNT_W-1:0] ovf_neg_cnt
);

    localparam int MID_W = midWidth(IN_W, IN_FRAC, OUT_FRAC);
    localparam int EXT_W = maxOf(MID_W, OUT_W) + 1;

    localparam logic signed [EXT_W-1:0] OUT_MAX = EXT_W'(outMax(OUT_W));
    localparam logic signed [EXT_W-1:0] OUT_MIN = EXT_W'(outMin(OUT_W));

    logic             s1Valid;
    logic [MID_W-1:0] s1Data;
    logic             s1Sat;
    logic             s2Load;

    logic signed [EXT_W-1:0] wide;
    logic                    isOvf;
    logic [OUT_W-1:0]        limited;

    logic             s2Valid_q, s2Valid_d;
    logic [OUT_W-1:0] oData_q, oData_d;
    logic             oOvf_q, oOvf_d;
    logic             oNeg_q, oNeg_d;
    logic [CNT_W-1:0] posCnt_q, posCnt_d;
    logic [CNT_W-1:0] negCnt_q, negCnt_d;
    logic             ovfEvent;

    assign s2Load = !s2Valid_q || o_ready;

    fx_round_stage #(
        .IN_W     (IN_W),
        .IN_FRAC  (IN_FRAC),
        .OUT_FRAC (OUT_FRAC),
        .MID_W    (MID_W)
    ) u_round (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (i_valid),
        .ready_o   (i_ready),
        .data_i    (i_data),
        .rnd_i     (i_rnd),
        .sat_i     (i_sat),
        .advance_i (s2Load),
        .valid_o   (s1Valid),
        .data_o    (s1Data),
        .sat_o     (s1Sat)
    );

    // Overflow is judged on the full-width quantized value so it is reported in both modes.
    always_comb begin
        wide    = EXT_W'(signed'(s1Data));
        isOvf   = (wide > OUT_MAX) || (wide < OUT_MIN);
        limited = wide[OUT_W-1:0];
        if (isOvf && (ovfMode_e'(s1Sat) == OVF_SAT)) begin
            limited = wide[EXT_W-1] ? OUT_MIN[OUT_W-1:0] : OUT_MAX[OUT_W-1:0];
        end
    end

    always_comb begin
        s2Valid_d = s2Valid_q;
        oData_d   = oData_q;
        oOvf_d    = oOvf_q;
        oNeg_d    = oNeg_q;
        if (s2Load) begin
            s2Valid_d = s1Valid;
            if (s1Valid) begin
                oData_d = limited;
                oOvf_d  = isOvf;
                oNeg_d  = wide[EXT_W-1];
            end
        end
    end

    assign ovfEvent = s2Valid_q && o_ready && oOvf_q;

    // Clear takes priority over a same-cycle event; counts stick at all-ones.
    always_comb begin
        posCnt_d = posCnt_q;
        negCnt_d = negCnt_q;
        if (cnt_clr) begin
            posCnt_d = '0;
            negCnt_d = '0;
        end else if (ovfEvent) begin
            if (!oNeg_q && (posCnt_q != '1)) posCnt_d = posCnt_q + 1'b1;
            if (oNeg_q && (negCnt_q != '1))  negCnt_d = negCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2Valid_q <= 1'b0;
            oData_q   <= '0;
            oOvf_q    <= 1'b0;
            oNeg_q    <= 1'b0;
            posCnt_q  <= '0;
            negCnt_q  <= '0;
        end else begin
            s2Valid_q <= s2Valid_d;
            oData_q   <= oData_d;
            oOvf_q    <= oOvf_d;
            oNeg_q    <= oNeg_d;
            posCnt_q  <= posCnt_d;
            negCnt_q  <= negCnt_d;
        end
    end

    assign o_valid     = s2Valid_q;
    assign o_data      = oData_q;
    assign o_ovf       = oOvf_q;
    assign ovf_pos_cnt = posCnt_q;
    assign ovf_neg_cnt = negCnt_q;

endmodule

// File: tb/tb_fx_requant_stream.sv
// Scoreboard bench for fx_requant_stream (13/8 in, 8/4 out, 4-bit counters so
// counter saturation is reachable quickly).
module tb_fx_requant_stream;

    localparam int IN_W  = 13;
    localparam int OUT_W = 8;
    localparam int CNT_W = 4;

    typedef struct {
        logic [7:0] data;
        logic       ovf;
        logic       neg;
        logic       checkLat;
        int         pushCycle;
    } expItem_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_valid;
    logic             i_ready;
    logic [IN_W-1:0]  i_data;
    logic [1:0]       i_rnd;
    logic             i_sat;
    logic             o_valid;
    logic             o_ready = 1'b0;
    logic [OUT_W-1:0] o_data;
    logic             o_ovf;
    logic             cnt_clr;
    logic [CNT_W-1:0] ovf_pos_cnt;
    logic [CNT_W-1:0] ovf_neg_cnt;

    expItem_t expQ[$];
    int testsRun    = 0;
    int testsFailed = 0;
    int cycle       = 0;
    int readyMode   = 1;
    int acceptCount = 0;
    int expPos      = 0;
    int expNeg      = 0;

    logic       holding = 1'b0;
    logic [7:0] heldData;
    logic       heldOvf;

    fx_requant_stream #(
        .IN_W(IN_W), .IN_FRAC(8), .OUT_W(OUT_W), .OUT_FRAC(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .i_rnd(i_rnd), .i_sat(i_sat),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_ovf(o_ovf),
        .cnt_clr(cnt_clr), .ovf_pos_cnt(ovf_pos_cnt), .ovf_neg_cnt(ovf_neg_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Downstream ready: 0 stalled, 1 always ready, otherwise random per cycle.
    always @(posedge clk) begin
        #2;
        case (readyMode)
            0:       o_ready = 1'b0;
            1:       o_ready = 1'b1;
            default: o_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Independent reference: integer arithmetic on the real-valued sample.
    function automatic void model(input logic [12:0] d, input logic [1:0] rnd, input logic sat,
                                  output logic [7:0] q8, output logic ovf);
        int v, fl, r, q;
        v  = {{19{d[12]}}, d};
        fl = v >>> 4;
        r  = v - fl * 16;
        case (rnd)
            2'd0:    q = fl;
            2'd1:    q = (r >= 8) ? fl + 1 : fl;
            2'd2:    q = ((r > 8) || ((r == 8) && ((fl & 1) != 0))) ? fl + 1 : fl;
            default: q = ((v < 0) && (r != 0)) ? fl + 1 : fl;
        endcase
        ovf = (q > 127) || (q < -128);
        if (sat && ovf) q8 = (q > 127) ? 8'h7F : 8'h80;
        else            q8 = 8'(q);
    endfunction

    task automatic applyStimulus(input logic [12:0] d, input logic [1:0] rnd, input logic sat,
                                 input logic [7:0] expData, input logic expOvf, input logic lat);
        int       waited;
        logic     accepted;
        expItem_t item;
        waited   = 0;
        accepted = 1'b0;
        i_valid  = 1'b1;
        i_data   = d;
        i_rnd    = rnd;
        i_sat    = sat;
        while (!accepted && waited < 200) begin
            @(negedge clk);
            if (i_ready) accepted = 1'b1;
            else waited++;
        end
        if (accepted) begin
            item.data      = expData;
            item.ovf       = expOvf;
            item.neg       = d[12];
            item.checkLat  = lat;
            item.pushCycle = cycle;
            expQ.push_back(item);
            acceptCount++;
        end else begin
            checkOutput("accept_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        readyMode = 1;
        for (int w = 0; w < 300; w++) begin
            @(negedge clk);
            if (expQ.size() == 0) break;
        end
        @(posedge clk);
        #1;
        checkOutput("drain_empty", expQ.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on each output transfer and checks held outputs.
    always @(negedge clk) begin
        expItem_t item;
        if (rst) begin
            holding = 1'b0;
        end else if (o_valid) begin
            if (holding) begin
                checkOutput("hold_data", 32'(o_data), 32'(heldData));
                checkOutput("hold_ovf", 32'(o_ovf), 32'(heldOvf));
            end
            if (o_ready) begin
                holding = 1'b0;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output", 32'(o_data), -1);
                end else begin
                    item = expQ.pop_front();
                    checkOutput("out_data", 32'(o_data), 32'(item.data));
                    checkOutput("out_ovf", 32'(o_ovf), 32'(item.ovf));
                    if (item.checkLat) checkOutput("latency", cycle - item.pushCycle, 2);
                    if (item.ovf && item.neg && expNeg < 15) expNeg++;
                    if (item.ovf && !item.neg && expPos < 15) expPos++;
                end
            end else begin
                holding  = 1'b1;
                heldData = o_data;
                heldOvf  = o_ovf;
            end
        end else if (holding) begin
            checkOutput("hold_valid", 32'(o_valid), 1);
            holding = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [12:0] rd;
        logic [1:0]  rr;
        logic        rs;
        logic [7:0]  mq;
        logic        mo;

        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_rnd   = 2'd0;
        i_sat   = 1'b0;
        cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_o_valid", 32'(o_valid), 0);
        checkOutput("rst_o_data", 32'(o_data), 0);
        checkOutput("rst_o_ovf", 32'(o_ovf), 0);
        checkOutput("rst_pos_cnt", 32'(ovf_pos_cnt), 0);
        checkOutput("rst_neg_cnt", 32'(ovf_neg_cnt), 0);
        checkOutput("rst_i_ready", 32'(i_ready), 1);
        @(posedge clk);
        #1;

        $display("[TB] directed rounding and overflow vectors");
        applyStimulus(13'h0018, 2'd0, 1'b0, 8'h01, 1'b0, 1'b1);
        applyStimulus(13'h0018, 2'd1, 1'b0, 8'h02, 1'b0, 1'b1);
        applyStimulus(13'h0018, 2'd2, 1'b0, 8'h02, 1'b0, 1'b1);
        applyStimulus(13'h0018, 2'd3, 1'b0, 8'h01, 1'b0, 1'b1);
        applyStimulus(13'h0028, 2'd2, 1'b0, 8'h02, 1'b0, 1'b1);
        applyStimulus(13'h0028, 2'd1, 1'b0, 8'h03, 1'b0, 1'b1);
        applyStimulus(13'h1FE8, 2'd3, 1'b0, 8'hFF, 1'b0, 1'b1);
        applyStimulus(13'h1FE8, 2'd0, 1'b0, 8'hFE, 1'b0, 1'b1);
        applyStimulus(13'h1FE8, 2'd1, 1'b0, 8'hFF, 1'b0, 1'b1);
        applyStimulus(13'h1FE8, 2'd2, 1'b0, 8'hFE, 1'b0, 1'b1);
        applyStimulus(13'h0008, 2'd2, 1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(13'h0038, 2'd2, 1'b0, 8'h04, 1'b0, 1'b1);
        applyStimulus(13'h0FFF, 2'd0, 1'b1, 8'h7F, 1'b1, 1'b1);
        applyStimulus(13'h0FFF, 2'd0, 1'b0, 8'hFF, 1'b1, 1'b1);
        applyStimulus(13'h1000, 2'd0, 1'b1, 8'h80, 1'b1, 1'b1);
        applyStimulus(13'h1000, 2'd0, 1'b0, 8'h00, 1'b1, 1'b1);
        applyStimulus(13'h07F0, 2'd0, 1'b1, 8'h7F, 1'b0, 1'b1);
        applyStimulus(13'h0800, 2'd0, 1'b0, 8'h80, 1'b1, 1'b1);
        applyStimulus(13'h1800, 2'd0, 1'b1, 8'h80, 1'b0, 1'b1);
        applyStimulus(13'h17F8, 2'd0, 1'b1, 8'h80, 1'b1, 1'b1);
        applyStimulus(13'h17F8, 2'd0, 1'b0, 8'h7F, 1'b1, 1'b1);
        applyStimulus(13'h17F8, 2'd3, 1'b1, 8'h80, 1'b0, 1'b1);
        applyStimulus(13'h07F8, 2'd1, 1'b1, 8'h7F, 1'b1, 1'b1);
        applyStimulus(13'h07F8, 2'd0, 1'b1, 8'h7F, 1'b0, 1'b1);
        drain();
        checkOutput("dir_pos_cnt", 32'(ovf_pos_cnt), 4);
        checkOutput("dir_neg_cnt", 32'(ovf_neg_cnt), 4);

        $display("[TB] backpressure for five cycles");
        readyMode   = 0;
        acceptCount = 0;
        fork
            begin
                for (int k = 1; k <= 6; k++)
                    applyStimulus(13'(k * 16), 2'd0, 1'b0, 8'(k), 1'b0, 1'b0);
            end
            begin
                for (int w = 0; w < 50 && acceptCount < 2; w++) @(negedge clk);
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    checkOutput("bp_i_ready_low", 32'(i_ready), 0);
                end
                readyMode = 1;
            end
        join
        drain();

        $display("[TB] random stream with random downstream ready");
        readyMode = 2;
        for (int n = 0; n < 100; n++) begin
            rd = 13'($urandom_range(0, 8191));
            rr = 2'($urandom_range(0, 3));
            rs = 1'($urandom_range(0, 1));
            model(rd, rr, rs, mq, mo);
            applyStimulus(rd, rr, rs, mq, mo, 1'b0);
        end
        drain();
        checkOutput("rand_pos_cnt", 32'(ovf_pos_cnt), expPos);
        checkOutput("rand_neg_cnt", 32'(ovf_neg_cnt), expNeg);

        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        expPos  = 0;
        expNeg  = 0;
        @(negedge clk);
        checkOutput("clr_pos_cnt", 32'(ovf_pos_cnt), 0);
        checkOutput("clr_neg_cnt", 32'(ovf_neg_cnt), 0);
        @(posedge clk);
        #1;

        $display("[TB] counter saturation");
        for (int n = 0; n < 17; n++) applyStimulus(13'h0FFF, 2'd0, 1'b1, 8'h7F, 1'b1, 1'b1);
        drain();
        checkOutput("sat_pos_cnt", 32'(ovf_pos_cnt), 15);
        checkOutput("sat_neg_cnt", 32'(ovf_neg_cnt), 0);

        $display("[TB] clear coinciding with an overflow transfer");
        readyMode = 0;
        applyStimulus(13'h1000, 2'd0, 1'b1, 8'h80, 1'b1, 1'b0);
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (o_valid) break;
        end
        checkOutput("held_before_clr", 32'(o_valid), 1);
        @(posedge clk);
        #1;
        cnt_clr   = 1'b1;
        readyMode = 1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        expPos  = 0;
        expNeg  = 0;
        @(negedge clk);
        checkOutput("clrwin_neg_cnt", 32'(ovf_neg_cnt), 0);
        checkOutput("clrwin_pos_cnt", 32'(ovf_pos_cnt), 0);
        @(posedge clk);
        #1;

        $display("[TB] reset with both stages full");
        applyStimulus(13'h0800, 2'd0, 1'b1, 8'h7F, 1'b1, 1'b1);
        drain();
        checkOutput("pre_rst_pos_cnt", 32'(ovf_pos_cnt), 1);
        readyMode = 0;
        applyStimulus(13'h0010, 2'd0, 1'b0, 8'h01, 1'b0, 1'b0);
        applyStimulus(13'h0020, 2'd0, 1'b0, 8'h02, 1'b0, 1'b0);
        rst = 1'b1;
        expQ.delete();
        @(posedge clk);
        #1;
        rst    = 1'b0;
        expPos = 0;
        expNeg = 0;
        @(negedge clk);
        checkOutput("mid_rst_o_valid", 32'(o_valid), 0);
        checkOutput("mid_rst_o_data", 32'(o_data), 0);
        checkOutput("mid_rst_pos_cnt", 32'(ovf_pos_cnt), 0);
        checkOutput("mid_rst_neg_cnt", 32'(ovf_neg_cnt), 0);
        checkOutput("mid_rst_i_ready", 32'(i_ready), 1);
        @(posedge clk);
        #1;
        readyMode = 1;
        applyStimulus(13'h0030, 2'd0, 1'b0, 8'h03, 1'b0, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fx_requant_stream.md
FX_REQUANT_STREAM -- requirements
Module: fx_requant_stream

Interface
REQ-001 Parameter IN_W, default 13, input sample width (signed two's complement).
REQ-002 Parameter IN_FRAC, default 8, input fractional bits.
REQ-003 Parameter OUT_W, default 8, output sample width (signed two's complement).
REQ-004 Parameter OUT_FRAC, default 4, output fractional bits; OUT_FRAC greater or less than IN_FRAC both legal.
REQ-005 Parameter CNT_W, default 16, event counter width.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 i_valid  input  1  input sample present.
REQ-009 i_ready  output  1  block accepts input this cycle.
REQ-010 i_data  input  IN_W  input sample.
REQ-011 i_rnd  input  2  rounding mode, sampled with the sample: 0 floor, 1 round-half-up, 2 convergent (half-even), 3 toward zero.
REQ-012 i_sat  input  1  overflow mode, sampled with the sample: 0 wrap, 1 saturate.
REQ-013 o_valid  output  1  output sample present.
REQ-014 o_ready  input  1  downstream accepts output.
REQ-015 o_data  output  OUT_W  requantized sample.
REQ-016 o_ovf  output  1  current o_data overflowed (saturated or wrapped).
REQ-017 cnt_clr  input  1  synchronous clear of both counters.
REQ-018 ovf_pos_cnt, ovf_neg_cnt  output  CNT_W each  positive/negative overflow event counts.

Function
REQ-019 Transfer occurs on a port only when valid and ready are both high in the same cycle.
REQ-020 Two pipeline stages: S1 quantization, S2 overflow and output register; latency exactly 2 cycles from input transfer to o_valid with no stall.
REQ-021 A stage advances when it is empty or the downstream stage advances; i_ready = NOT S1 full OR S1 advances (full throughput, 1 sample/cycle).
REQ-022 Held o_data/o_ovf/o_valid stay stable while o_valid=1 and o_ready=0.
REQ-023 S1: if OUT_FRAC >= IN_FRAC, left shift by OUT_FRAC-IN_FRAC, zero-fill LSBs, no rounding; else drop D=IN_FRAC-OUT_FRAC LSBs per i_rnd.
REQ-024 S1 intermediate width IN_W-max(D,0)+max(-D,0)+1 bits so the rounding carry never wraps.
REQ-025 Round-half-up adds 2^(D-1) before floor; convergent rounds exact halves to even LSB; toward-zero adds 2^D-1 to negatives before floor.
REQ-026 S2 saturate: values above 2^(OUT_W-1)-1 clamp to it, below -2^(OUT_W-1) clamp to it; wrap: keep low OUT_W bits.
REQ-027 o_ovf=1 when the S1 value is outside OUT_W range, in either mode.
REQ-028 Counters increment once per output transfer with o_ovf=1 (sign selects counter), saturate at all-ones, never wrap.
REQ-029 cnt_clr wins over a simultaneous increment; counters read 0 next cycle.
REQ-030 Mode bits travel with their sample; changing i_rnd/i_sat mid-stream affects only later-accepted samples.

Reset
REQ-031 rst clears both stage valid flags, o_valid=0, o_ovf=0, o_data=0, counters=0; i_ready=1 in the first cycle after reset deasserts.
REQ-032 rst mid-stream discards all in-flight samples; no partial output is ever presented.

Structure
REQ-033 Rounding/overflow mode encodings and range-limit helper constants live in the shared fixed-point package.
REQ-034 One sub-module, fx_round_stage (S1 quantize + register), instantiated once; S2 and counters in the top.

Verification (IN 13/8, OUT 8/4, ready held high unless stated)
REQ-035 i_data=0x0018 (1.5 LSB out): floor->0x01, half-up->0x02, convergent->0x02, toward-zero->0x01; 0x0028: convergent->0x02, half-up->0x03; -0x0018: toward-zero->0xFF, floor->0xFE.
REQ-036 i_data=0x0FFF sat=1 -> 0x7F o_ovf=1 pos_cnt+1; sat=0 -> 0xFF o_ovf=1; i_data=0x1000 sat=1 -> 0x80, sat=0 -> 0x00, neg_cnt+1.
REQ-037 Back-to-back 100 random samples with o_ready toggling randomly -> output order, count and values match model, no drops or duplicates, held data stable.
REQ-038 o_ready=0 for 5 cycles while streaming -> i_ready falls after two samples buffered, resumes with no loss.
REQ-039 Counter at all-ones plus overflow -> stays all-ones; cnt_clr with overflow in same cycle -> 0.
REQ-040 rst asserted with both stages full -> o_valid=0 next cycle, counters 0, first post-reset output appears 2 cycles after first accept.
